memory_router: RTL and testbench
================================

# memory_router

Single-clock memory router between the CPU data port and two backing stores: an internal synchronous SRAM for low addresses and the external LPDDR2 controller for everything above. It replaces the fixed-size combinational split with a registered request/acknowledge handshake, a CPU stall output, an external bus timeout with error reporting, and parametrised address, data and SRAM sizes. It sits between the CPU memory stage and the LPDDR2 controller.

## Interface
- ADDR_W, 30: CPU word-address width.
- DATA_W, 32: data width.
- SRAM_AW, 12: SRAM address width; SRAM depth is 2**SRAM_AW words.
- EXT_AW, 27: external address width.
- TIMEOUT, 255: maximum external wait cycles (0 = no timeout); counter is 16 bits.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_in  in  ADDR_W  CPU word address.
- data_in  in  DATA_W  CPU write data.
- mem_wren  in  1  write request.
- mem_rren  in  1  read request.
- E  in  1  request qualifier; requests are ignored when low.
- out  out  DATA_W  read data.
- stall  out  1  CPU must hold all inputs while high.
- bus_err  out  1  one-cycle pulse: external access timed out.
- address  out  EXT_AW  registered external address.
- write_data  out  DATA_W  registered external write data.
- read_req  out  1  registered external read request.
- write_req  out  1  registered external write request.
- ext_ready  in  1  controller accepts the pending request this cycle.
- read_valid  in  1  read_data is valid this cycle.
- read_data  in  DATA_W  external read data.

## Operation
- States: IDLE, SRAM_RD, EXT_REQ, EXT_WAIT, DONE.
- Accept: in IDLE with E && (mem_wren || mem_rren). If both are high, the write wins and the read is dropped.
- Region: SRAM when addr_in < 2**SRAM_AW, otherwise external. External address = addr_in[EXT_AW-1:0], truncated.
- SRAM write: written at the accept edge; stall stays 0; state remains IDLE.
- SRAM read: stall=1 in the accept cycle, then SRAM_RD. In SRAM_RD, out = SRAM q, stall=0, out_q loads q; then IDLE.
- External accept:
  - stall=1; address, write_data and the op are captured.
  - Next state EXT_REQ.
  - read_req or write_req goes high from the next cycle.
- EXT_REQ: request held high until a cycle with ext_ready=1. Request drops on that edge; a write goes to DONE, a read goes to EXT_WAIT.
- EXT_WAIT: wait for read_valid; on that cycle out_q <= read_data and the state goes to DONE. ext_ready is ignored here.
- DONE: stall=0, out = out_q, next state IDLE. No new request is accepted in DONE.
- read_valid outside EXT_WAIT is ignored.
- Timeout:
  - A counter clears on external accept and increments every cycle in EXT_REQ or EXT_WAIT.
  - When it equals TIMEOUT (TIMEOUT≠0), the request drops, out_q <= all ones, state goes to DONE, and bus_err pulses high during DONE.
  - If read_valid or ext_ready arrives in the same cycle as the timeout, the normal completion wins and no error is raised.
- out outside SRAM_RD is out_q; it holds its last value.
- stall in IDLE equals the accept condition for an SRAM read or any external access; otherwise 0.
- Reset (asynchronous, also mid-transaction): state IDLE, read_req=write_req=0, address=0, write_data=0, out_q=0, bus_err=0, counter=0. An in-flight external access is abandoned.

## Timing
- SRAM write: 0 stall cycles. SRAM read: 1 stall cycle, data on out in the following cycle.
- External write with ext_ready held high: stall during accept and EXT_REQ (2 cycles); DONE in the third cycle.
- External read: minimum 3 stall cycles (accept, EXT_REQ, EXT_WAIT with read_valid); data on out in DONE.
- Request outputs are registered and never glitch; at most one of read_req/write_req is high.
- Back-to-back: the next request is accepted no earlier than the cycle after DONE, or after SRAM_RD for SRAM reads.

## Test plan
- Reset, then SRAM write addr 0x005 data 0xDEADBEEF, then read 0x005 -> write stall=0; read stall=1 for one cycle; out=0xDEADBEEF next cycle.
- Ext write addr 0x1000 data 0x12345678, ext_ready held low 3 cycles -> write_req high exactly 4 cycles, address=0x1000, write_data=0x12345678; stall releases in DONE.
- Ext read addr 0x2000, ext_ready at first EXT_REQ cycle, read_valid 5 cycles later with 0xCAFEF00D -> out=0xCAFEF00D in DONE; bus_err=0.
- TIMEOUT=8, ext read with ext_ready never asserted -> read_req drops after 8 cycles; out=0xFFFFFFFF; bus_err one-cycle pulse; stall=0.
- Both mem_wren and mem_rren high at ext addr -> only write_req is asserted. read_valid in IDLE -> out unchanged.
- Assert rst during EXT_WAIT -> read_req=0, stall=0, out=0 immediately. A subsequent SRAM read completes normally.

Source files
------------

// File: rtl/memory_router.sv
// Routes CPU data-port accesses to an internal synchronous SRAM (low addresses) or to the
// external LPDDR2 controller, using a registered request/acknowledge handshake and a CPU stall.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | ready for a new access; SRAM writes complete here with no stall
// S_SRAM_RD  | SRAM read data is on out and is loaded into out_q
// S_EXT_REQ  | read_req/write_req held high until ext_ready
// S_EXT_WAIT | external read accepted, waiting for read_valid
// S_DONE     | access complete; stall released, out shows out_q
module memory_router #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 12,
  parameter int EXT_AW  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_wren,
  input  logic              mem_rren,
  input  logic              E,
  output logic [DATA_W-1:0] out,
  output logic              stall,
  output logic              bus_err,
  output logic [EXT_AW-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              read_req,
  output logic              write_req,
  input  logic              ext_ready,
  input  logic              read_valid,
  input  logic [DATA_W-1:0] read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRAM_RD,
    S_EXT_REQ,
    S_EXT_WAIT,
    S_DONE
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);
  localparam bit          LP_TO_EN   = (TIMEOUT != 0);

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [0:(2**SRAM_AW)-1];
  logic [DATA_W-1:0]   r_sram_q;
  logic [DATA_W-1:0]   r_out_q;
  logic [15:0]         r_cnt;
  logic [EXT_AW-1:0]   r_address;
  logic [DATA_W-1:0]   r_write_data;
  logic                r_read_req;
  logic                r_write_req;
  logic                r_bus_err;

  logic                w_accept;
  logic                w_is_sram;
  logic                w_sram_wr;
  logic                w_sram_rd;
  logic                w_ext_acc;
  logic                w_in_ext;
  logic [15:0]         w_cnt_inc;
  logic                w_timeout;

  // Write wins when both enables are high, so a read is only a read when mem_wren is low.
  assign w_accept  = (r_state == S_IDLE) && E && (mem_wren || mem_rren);
  assign w_is_sram = ((addr_in >> SRAM_AW) == '0);
  assign w_sram_wr = w_accept && w_is_sram && mem_wren;
  assign w_sram_rd = w_accept && w_is_sram && !mem_wren;
  assign w_ext_acc = w_accept && !w_is_sram;

  assign w_in_ext  = (r_state == S_EXT_REQ) || (r_state == S_EXT_WAIT);
  assign w_cnt_inc = r_cnt + 16'd1;
  // Fires on the cycle that would bring the wait count up to TIMEOUT.
  assign w_timeout = LP_TO_EN && w_in_ext && (w_cnt_inc == LP_TIMEOUT);

  always_ff @(posedge clk) begin
    if (w_sram_wr) begin
      r_mem[addr_in[SRAM_AW-1:0]] <= data_in;
    end
    if (w_sram_rd) begin
      r_sram_q <= r_mem[addr_in[SRAM_AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_out_q      <= '0;
      r_cnt        <= '0;
      r_address    <= '0;
      r_write_data <= '0;
      r_read_req   <= 1'b0;
      r_write_req  <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sram_rd) begin
            r_state <= S_SRAM_RD;
          end else if (w_ext_acc) begin
            r_address    <= addr_in[EXT_AW-1:0];
            r_write_data <= data_in;
            r_write_req  <= mem_wren;
            r_read_req   <= !mem_wren;
            r_cnt        <= '0;
            r_state      <= S_EXT_REQ;
          end
        end
        S_SRAM_RD: begin
          r_out_q <= r_sram_q;
          r_state <= S_IDLE;
        end
        S_EXT_REQ: begin
          r_cnt <= w_cnt_inc;
          if (ext_ready) begin
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_state     <= r_write_req ? S_DONE : S_EXT_WAIT;
          end else if (w_timeout) begin
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_out_q     <= '1;
            r_bus_err   <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_EXT_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (read_valid) begin
            r_out_q <= read_data;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_out_q   <= '1;
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE:     stall = w_sram_rd || w_ext_acc;
      S_EXT_REQ:  stall = 1'b1;
      S_EXT_WAIT: stall = 1'b1;
      default:    stall = 1'b0;
    endcase
  end

  assign out        = (r_state == S_SRAM_RD) ? r_sram_q : r_out_q;
  assign bus_err    = r_bus_err;
  assign address    = r_address;
  assign write_data = r_write_data;
  assign read_req   = r_read_req;
  assign write_req  = r_write_req;

endmodule

// File: tb/tb_memory_router.sv
// Directed bench for memory_router: inputs change on the falling edge, outputs are checked 1ns later.
module tb_memory_router;

  logic        clk;
  logic        rst;
  logic [29:0] addr_in;
  logic [31:0] data_in;
  logic        mem_wren;
  logic        mem_rren;
  logic        E;
  logic [31:0] out;
  logic        stall;
  logic        bus_err;
  logic [26:0] address;
  logic [31:0] write_data;
  logic        read_req;
  logic        write_req;
  logic        ext_ready;
  logic        read_valid;
  logic [31:0] read_data;

  int n_assert = 0;
  int n_fail   = 0;

  memory_router #(
    .ADDR_W (30),
    .DATA_W (32),
    .SRAM_AW(12),
    .EXT_AW (27),
    .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .mem_wren  (mem_wren),
    .mem_rren  (mem_rren),
    .E         (E),
    .out       (out),
    .stall     (stall),
    .bus_err   (bus_err),
    .address   (address),
    .write_data(write_data),
    .read_req  (read_req),
    .write_req (write_req),
    .ext_ready (ext_ready),
    .read_valid(read_valid),
    .read_data (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    E = 1'b0; mem_wren = 1'b0; mem_rren = 1'b0;
    ext_ready = 1'b0; read_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr_in = '0; data_in = '0; read_data = '0;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_rreq", 32'(read_req), 32'd0);
    chk("rst_wreq", 32'(write_req), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    rst = 1'b0;

    // SRAM write then read of 0x005
    @(negedge clk); E = 1; mem_wren = 1; addr_in = 30'h005; data_in = 32'hDEADBEEF; #1;
    chk("sw_stall", 32'(stall), 32'd0);
    @(negedge clk); mem_wren = 0; mem_rren = 1; data_in = '0; #1;
    chk("sr_stall_acc", 32'(stall), 32'd1);
    @(negedge clk); idle_inputs(); #1;
    chk("sr_out", out, 32'hDEADBEEF);
    chk("sr_stall_rd", 32'(stall), 32'd0);
    @(negedge clk); #1;
    chk("sr_out_hold", out, 32'hDEADBEEF);

    // External write 0x1000, ext_ready low for 3 EXT_REQ cycles
    @(negedge clk); E = 1; mem_wren = 1; addr_in = 30'h1000; data_in = 32'h12345678; #1;
    chk("ew_stall_acc", 32'(stall), 32'd1);
    chk("ew_wreq_acc", 32'(write_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ext_ready = (i == 3); #1;
      chk("ew_wreq", 32'(write_req), 32'd1);
      chk("ew_rreq", 32'(read_req), 32'd0);
      chk("ew_stall", 32'(stall), 32'd1);
      if (i == 0) begin
        chk("ew_addr", 32'(address), 32'h1000);
        chk("ew_wdata", write_data, 32'h12345678);
      end
    end
    @(negedge clk); idle_inputs(); #1;
    chk("ew_done_wreq", 32'(write_req), 32'd0);
    chk("ew_done_stall", 32'(stall), 32'd0);
    chk("ew_done_berr", 32'(bus_err), 32'd0);

    // External read 0x2000, ready on first EXT_REQ cycle, read_valid 5 cycles later
    @(negedge clk); E = 1; mem_rren = 1; addr_in = 30'h2000; #1;
    chk("er_stall_acc", 32'(stall), 32'd1);
    @(negedge clk); ext_ready = 1; #1;
    chk("er_rreq", 32'(read_req), 32'd1);
    chk("er_wreq", 32'(write_req), 32'd0);
    chk("er_addr", 32'(address), 32'h2000);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); ext_ready = 0; #1;
      chk("er_wait_stall", 32'(stall), 32'd1);
      chk("er_wait_rreq", 32'(read_req), 32'd0);
    end
    @(negedge clk); read_valid = 1; read_data = 32'hCAFEF00D; #1;
    chk("er_valid_stall", 32'(stall), 32'd1);
    @(negedge clk); idle_inputs(); read_data = '0; #1;
    chk("er_out", out, 32'hCAFEF00D);
    chk("er_stall_done", 32'(stall), 32'd0);
    chk("er_berr", 32'(bus_err), 32'd0);

    // Timeout: ext read, ext_ready never asserted
    @(negedge clk); E = 1; mem_rren = 1; addr_in = 30'h3000; #1;
    chk("to_stall_acc", 32'(stall), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("to_rreq", 32'(read_req), 32'd1);
      chk("to_berr_wait", 32'(bus_err), 32'd0);
    end
    @(negedge clk); idle_inputs(); #1;
    chk("to_rreq_drop", 32'(read_req), 32'd0);
    chk("to_out", out, 32'hFFFFFFFF);
    chk("to_berr", 32'(bus_err), 32'd1);
    chk("to_stall", 32'(stall), 32'd0);
    @(negedge clk); #1;
    chk("to_berr_pulse", 32'(bus_err), 32'd0);

    // Write and read both high at an external address: write wins
    @(negedge clk); E = 1; mem_wren = 1; mem_rren = 1; addr_in = 30'h4000; data_in = 32'hA5A5A5A5; #1;
    chk("wr_stall_acc", 32'(stall), 32'd1);
    @(negedge clk); ext_ready = 1; #1;
    chk("wr_wreq", 32'(write_req), 32'd1);
    chk("wr_rreq", 32'(read_req), 32'd0);
    @(negedge clk); idle_inputs(); #1;
    chk("wr_done_stall", 32'(stall), 32'd0);
    chk("wr_done_rreq", 32'(read_req), 32'd0);
    @(negedge clk); read_valid = 1; read_data = 32'h11111111; #1;
    chk("rv_idle_out", out, 32'hFFFFFFFF);
    @(negedge clk); read_valid = 0; #1;
    chk("rv_idle_hold", out, 32'hFFFFFFFF);

    // Reset during EXT_WAIT, then an SRAM read
    @(negedge clk); E = 1; mem_rren = 1; addr_in = 30'h5000; #1;
    @(negedge clk); ext_ready = 1; #1;
    chk("rw_rreq", 32'(read_req), 32'd1);
    @(negedge clk); ext_ready = 0; #1;
    chk("rw_wait_stall", 32'(stall), 32'd1);
    #1; rst = 1; idle_inputs(); #1;
    chk("rw_rreq_rst", 32'(read_req), 32'd0);
    chk("rw_stall_rst", 32'(stall), 32'd0);
    chk("rw_out_rst", out, 32'd0);
    @(negedge clk); rst = 0;
    @(negedge clk); E = 1; mem_rren = 1; addr_in = 30'h005; #1;
    chk("pr_stall", 32'(stall), 32'd1);
    @(negedge clk); idle_inputs(); #1;
    chk("pr_out", out, 32'hDEADBEEF);
    chk("pr_stall_rd", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
